// File: rtl/out_serial_tx.sv
// rtl/out_serial_tx.sv - buffered 16-bit word to dual 8N1 UART frame transmitter
module out_serial_tx #(
  parameter int DEPTH   = 4,
  parameter int CLK_DIV = 434
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic [15:0]            din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   drop,
  output logic                   txd
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLK_DIV - 1);
  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic          byte_q, byte_d;
  logic [15:0]   shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;

  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          drop_q, drop_d;
  logic [15:0]   mem_q [DEPTH];

  logic          pop;
  logic          push;
  logic          bit_end;

  assign bit_end = (cnt_q == BIT_LAST);

  // Transmitter next-state: bit timer, frame sequencing and registered line/busy values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bitcnt_d = bitcnt_q;
    byte_d   = byte_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!empty_q) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q[AW-1:0]];
          byte_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d    = '0;
          bitcnt_d = 3'd0;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[15:1]};
          if (bitcnt_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!byte_q) begin
            // high byte already sits in shift[7:0] after eight shifts
            byte_d  = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // FIFO bookkeeping: a full FIFO still accepts a write in the cycle the head is popped
  always_comb begin
    push    = wr && (!full_q || pop);
    wptr_d  = wptr_q + (AW + 1)'(push);
    rptr_d  = rptr_q + (AW + 1)'(pop);
    level_d = wptr_d - rptr_d;
    full_d  = (level_d == DEPTH_W);
    empty_d = (level_d == '0);
    drop_d  = wr && !push;
  end

  // State and status registers; reset abandons any frame and empties the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bitcnt_q <= 3'd0;
      byte_q   <= 1'b0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      byte_q   <= byte_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      drop_q   <= drop_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= din;
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign level = level_q;
  assign busy  = busy_q;
  assign drop  = drop_q;
  assign txd   = txd_q;

endmodule

// File: tb/tb_out_serial_tx.sv
// tb/tb_out_serial_tx.sv - self-checking bench for out_serial_tx
module tb_out_serial_tx;

  localparam int DEP = 4;
  localparam int CD  = 4;
  localparam int LW  = $clog2(DEP) + 1;
  localparam int WORD_CYC = 20 * CD;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr;
  logic [15:0]   din;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          busy;
  logic          drop;
  logic          txd;

  int n_chk  = 0;
  int n_fail = 0;

  out_serial_tx #(.DEPTH(DEP), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .wr(wr), .din(din), .full(full), .empty(empty),
    .level(level), .busy(busy), .drop(drop), .txd(txd)
  );

  always #5 clk = ~clk;

  // Reference model: occupancy queue plus "transmitter free after cycle" arithmetic
  logic [15:0] mq[$];
  logic [15:0] exp_q[$];
  int          cyc = 0;
  int          busy_until = 0;
  bit          m_drop = 1'b0;
  bit          m_pop;
  bit          m_acc;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst === 1'b1) begin
      mq.delete();
      m_drop = 1'b0;
      busy_until = 0;
    end else begin
      m_pop = (mq.size() > 0) && (cyc > busy_until);
      m_acc = (wr === 1'b1) && ((mq.size() < DEP) || m_pop);
      if (m_pop) begin
        exp_q.push_back(mq.pop_front());
        busy_until = cyc + WORD_CYC;
      end
      if (m_acc) mq.push_back(din);
      m_drop = (wr === 1'b1) && !m_acc;
    end
  end

  function automatic logic [LW+3:0] model_flags();
    int n = mq.size();
    return {LW'(n), n == DEP, n == 0, cyc < busy_until, m_drop};
  endfunction

  // Line decoder: captures one 20-bit-period word, checking every sample of every bit
  logic [15:0] rx_q[$];
  bit          rx_ok_q[$];

  always begin : line_mon
    logic [15:0] w;
    bit ok, ab;
    logic v;
    int idx;
    @(negedge clk);
    if (rst === 1'b0 && txd === 1'b0) begin
      w = '0; ok = 1'b1; ab = 1'b0;
      for (int b = 0; b < 20; b++) begin
        for (int s = 0; s < CD; s++) begin
          if (!(b == 0 && s == 0)) @(negedge clk);
          if (rst !== 1'b0) ab = 1'b1;
          if (ab) break;
          v = txd;
          if (busy !== 1'b1) ok = 1'b0;
          if (b == 0 || b == 10) begin
            if (v !== 1'b0) ok = 1'b0;
          end else if (b == 9 || b == 19) begin
            if (v !== 1'b1) ok = 1'b0;
          end else begin
            idx = (b < 10) ? b - 1 : b - 3;
            if (s == 0) w[idx] = v;
            else if (w[idx] !== v) ok = 1'b0;
          end
        end
        if (ab) break;
      end
      if (!ab) begin
        rx_q.push_back(w);
        rx_ok_q.push_back(ok);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; wr = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    n_chk++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset.txd: got %b expected 1", txd); end
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset.empty: got %b expected 1", empty); end
    n_chk++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset.full: got %b expected 0", full); end
    n_chk++; if (level !== '0) begin n_fail++; $display("FAIL reset.level: got %0d expected 0", level); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset.busy: got %b expected 0", busy); end
    n_chk++; if (drop !== 1'b0) begin n_fail++; $display("FAIL reset.drop: got %b expected 0", drop); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_word();
    logic tx_hist [0:99];
    logic [19:0] seq = 20'b00101101010101001011;
    int busy_cnt = 0;
    bit shape_bad = 1'b0;
    rx_q.delete(); rx_ok_q.delete(); exp_q.delete();
    wr = 1'b1; din = 16'hA55A;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      wr = 1'b0;
      tx_hist[i] = txd;
      if (busy === 1'b1) busy_cnt++;
      n_chk++;
      if ({level, full, empty, busy, drop} !== model_flags()) begin
        n_fail++;
        $display("FAIL single.flags cyc %0d: got %b expected %b", i, {level, full, empty, busy, drop}, model_flags());
      end
      if (i == 0) begin
        n_chk++; if (txd !== 1'b1 || level !== LW'(1)) begin n_fail++; $display("FAIL single.latency0: txd %b level %0d expected 1 and 1", txd, level); end
      end
      if (i == 1) begin
        n_chk++; if (txd !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single.latency1: txd %b busy %b expected 0 and 1", txd, busy); end
      end
    end
    for (int j = 0; j < 20; j++)
      for (int s = 0; s < CD; s++)
        if (tx_hist[1 + j * CD + s] !== seq[19 - j]) shape_bad = 1'b1;
    n_chk++; if (shape_bad || tx_hist[81] !== 1'b1) begin n_fail++; $display("FAIL single.txd_sequence: waveform differs from expected A55A frames"); end
    n_chk++; if (busy_cnt != WORD_CYC) begin n_fail++; $display("FAIL single.busy_len: got %0d expected %0d", busy_cnt, WORD_CYC); end
    n_chk++;
    if (rx_q.size() != 1 || rx_q[0] !== 16'hA55A || !rx_ok_q[0]) begin
      n_fail++;
      $display("FAIL single.rx: got %0d words first %h expected 1 word a55a", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 16'h0);
    end
  endtask

  task automatic test_zero_word();
    rx_q.delete(); rx_ok_q.delete(); exp_q.delete();
    wr = 1'b1; din = 16'h0000;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      wr = 1'b0;
      n_chk++;
      if ({level, full, empty, busy, drop} !== model_flags()) begin
        n_fail++;
        $display("FAIL zero.flags cyc %0d: got %b expected %b", i, {level, full, empty, busy, drop}, model_flags());
      end
    end
    n_chk++;
    if (rx_q.size() != 1 || rx_q[0] !== 16'h0000 || !rx_ok_q[0]) begin
      n_fail++;
      $display("FAIL zero.rx: got %0d words first %h expected 1 word 0000", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 16'hFFFF);
    end
  endtask

  task automatic test_fill_overflow();
    logic [15:0] d [6];
    rx_q.delete(); rx_ok_q.delete(); exp_q.delete();
    for (int j = 0; j < 6; j++) d[j] = 16'($urandom());
    for (int i = 0; i < 6 + 5 * (WORD_CYC + 1) + 10; i++) begin
      if (i < 6) begin wr = 1'b1; din = d[i]; end else wr = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({level, full, empty, busy, drop} !== model_flags()) begin
        n_fail++;
        $display("FAIL fill.flags cyc %0d: got %b expected %b", i, {level, full, empty, busy, drop}, model_flags());
      end
      if (i == 5) begin
        n_chk++; if (drop !== 1'b1 || level !== LW'(4) || full !== 1'b1) begin n_fail++; $display("FAIL fill.overflow: drop %b level %0d full %b expected 1 4 1", drop, level, full); end
      end
      if (i == 6) begin
        n_chk++; if (drop !== 1'b0) begin n_fail++; $display("FAIL fill.drop_width: got %b expected 0", drop); end
      end
    end
    wr = 1'b0;
    n_chk++; if (rx_q.size() != 5) begin n_fail++; $display("FAIL fill.rx_count: got %0d expected 5", rx_q.size()); end
    for (int j = 0; j < 5 && j < rx_q.size(); j++) begin
      n_chk++; if (rx_q[j] !== d[j] || !rx_ok_q[j]) begin n_fail++; $display("FAIL fill.rx[%0d]: got %h expected %h", j, rx_q[j], d[j]); end
    end
  endtask

  task automatic test_write_on_pop();
    logic [15:0] d [6];
    rx_q.delete(); rx_ok_q.delete(); exp_q.delete();
    for (int j = 0; j < 6; j++) d[j] = 16'($urandom());
    for (int i = 0; i < 6 * (WORD_CYC + 1) + 10; i++) begin
      wr = (i < 5) || (i == WORD_CYC + 2);
      din = (i < 5) ? d[i] : d[5];
      @(negedge clk);
      n_chk++;
      if ({level, full, empty, busy, drop} !== model_flags()) begin
        n_fail++;
        $display("FAIL wpop.flags cyc %0d: got %b expected %b", i, {level, full, empty, busy, drop}, model_flags());
      end
      if (i == WORD_CYC + 1) begin
        n_chk++; if (full !== 1'b1 || level !== LW'(4)) begin n_fail++; $display("FAIL wpop.prefull: full %b level %0d expected 1 4", full, level); end
      end
      if (i == WORD_CYC + 2) begin
        n_chk++; if (drop !== 1'b0 || level !== LW'(4) || full !== 1'b1) begin n_fail++; $display("FAIL wpop.accept: drop %b level %0d full %b expected 0 4 1", drop, level, full); end
      end
    end
    wr = 1'b0;
    n_chk++; if (rx_q.size() != 6) begin n_fail++; $display("FAIL wpop.rx_count: got %0d expected 6", rx_q.size()); end
    for (int j = 0; j < 6 && j < rx_q.size(); j++) begin
      n_chk++; if (rx_q[j] !== d[j] || !rx_ok_q[j]) begin n_fail++; $display("FAIL wpop.rx[%0d]: got %h expected %h", j, rx_q[j], d[j]); end
    end
  endtask

  task automatic test_pointer_wrap();
    int n = 0;
    rx_q.delete(); rx_ok_q.delete(); exp_q.delete();
    for (int i = 0; i < 12 * (WORD_CYC + 1); i++) begin
      if (full === 1'b0 && n < 10) begin wr = 1'b1; din = 16'(n + 1); n++; end
      else wr = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({level, full, empty, busy, drop} !== model_flags()) begin
        n_fail++;
        $display("FAIL wrap.flags cyc %0d: got %b expected %b", i, {level, full, empty, busy, drop}, model_flags());
      end
    end
    wr = 1'b0;
    n_chk++; if (rx_q.size() != 10) begin n_fail++; $display("FAIL wrap.rx_count: got %0d expected 10", rx_q.size()); end
    for (int j = 0; j < 10 && j < rx_q.size(); j++) begin
      n_chk++; if (rx_q[j] !== 16'(j + 1) || !rx_ok_q[j]) begin n_fail++; $display("FAIL wrap.rx[%0d]: got %h expected %h", j, rx_q[j], 16'(j + 1)); end
    end
  endtask

  task automatic test_random();
    int bad_shape = 0;
    rx_q.delete(); rx_ok_q.delete(); exp_q.delete();
    for (int i = 0; i < 1700; i++) begin
      wr  = (i < 1200) && ($urandom_range(0, 99) < 8);
      din = 16'($urandom());
      @(negedge clk);
      n_chk++;
      if ({level, full, empty, busy, drop} !== model_flags()) begin
        n_fail++;
        $display("FAIL random.flags cyc %0d: got %b expected %b", i, {level, full, empty, busy, drop}, model_flags());
      end
    end
    wr = 1'b0;
    n_chk++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random.rx_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int j = 0; j < rx_q.size() && j < exp_q.size(); j++) begin
      n_chk++; if (rx_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL random.rx[%0d]: got %h expected %h", j, rx_q[j], exp_q[j]); end
      if (!rx_ok_q[j]) bad_shape++;
    end
    n_chk++; if (bad_shape != 0) begin n_fail++; $display("FAIL random.frame_shape: got %0d malformed frames expected 0", bad_shape); end
  endtask

  task automatic test_reset_midstream();
    int txd_low = 0;
    rx_q.delete(); rx_ok_q.delete(); exp_q.delete();
    for (int i = 0; i < 33; i++) begin
      wr = (i < 3); din = 16'($urandom());
      @(negedge clk);
    end
    wr = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_chk++; if (txd !== 1'b1) begin n_fail++; $display("FAIL rstmid.txd: got %b expected 1", txd); end
    n_chk++; if (empty !== 1'b1 || level !== '0) begin n_fail++; $display("FAIL rstmid.fifo: empty %b level %0d expected 1 0", empty, level); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid.busy: got %b expected 0", busy); end
    for (int i = 0; i < 3 * (WORD_CYC + 1); i++) begin
      @(negedge clk);
      if (txd !== 1'b1) txd_low++;
      n_chk++;
      if ({level, full, empty, busy, drop} !== model_flags()) begin
        n_fail++;
        $display("FAIL rstmid.flags cyc %0d: got %b expected %b", i, {level, full, empty, busy, drop}, model_flags());
      end
    end
    n_chk++; if (txd_low != 0) begin n_fail++; $display("FAIL rstmid.quiet: got %0d non-idle cycles expected 0", txd_low); end
    n_chk++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL rstmid.rx: got %0d words expected 0", rx_q.size()); end
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; din = '0;
    test_reset();
    test_single_word();
    test_zero_word();
    test_fill_overflow();
    test_write_on_pop();
    test_pointer_wrap();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
